// File: rtl/sim_sram_window.sv
// Simulation-only bus interceptor: requests inside [start_addr_i, start_addr_i+SizeBytes)
// are served locally, everything else is forwarded. Optional storage via SIM_SRAM_READBACK_EN.
module sim_sram_window #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int SRCW      = 8,
  parameter int SizeBytes = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [AW-1:0]     start_addr_i,
  input  logic              h_req_valid_i,
  output logic              h_req_ready_o,
  input  logic              h_req_write_i,
  input  logic [AW-1:0]     h_req_addr_i,
  input  logic [DW-1:0]     h_req_wdata_i,
  input  logic [DW/8-1:0]   h_req_mask_i,
  input  logic [SRCW-1:0]   h_req_source_i,
  output logic              h_rsp_valid_o,
  input  logic              h_rsp_ready_i,
  output logic [DW-1:0]     h_rsp_rdata_o,
  output logic [SRCW-1:0]   h_rsp_source_o,
  output logic              h_rsp_error_o,
  output logic              d_req_valid_o,
  input  logic              d_req_ready_i,
  output logic              d_req_write_o,
  output logic [AW-1:0]     d_req_addr_o,
  output logic [DW-1:0]     d_req_wdata_o,
  output logic [DW/8-1:0]   d_req_mask_o,
  output logic [SRCW-1:0]   d_req_source_o,
  input  logic              d_rsp_valid_i,
  output logic              d_rsp_ready_o,
  input  logic [DW-1:0]     d_rsp_rdata_i,
  input  logic [SRCW-1:0]   d_rsp_source_i,
  input  logic              d_rsp_error_i,
  output logic              wr_valid_o,
  output logic [AW-1:0]     wr_addr_o,
  output logic [DW-1:0]     wr_data_o
);
  localparam int MW    = DW / 8;
  localparam int OFFB  = (MW > 1) ? $clog2(MW) : 0;
  localparam int WORDS = SizeBytes / MW;
  localparam int IW    = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {IDLE, FWD, LOCAL} state_e;

  state_e            state_q, state_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  logic [SRCW-1:0]   source_q, source_d;
  logic              wr_valid_q, wr_valid_d;
  logic [AW-1:0]     wr_addr_q, wr_addr_d;
  logic [DW-1:0]     wr_data_q, wr_data_d;

  logic [AW:0]       addr_ext, lo_ext, hi_ext;
  logic              hit, acc_local, acc_fwd;
  logic [DW-1:0]     rd_word;

  // Bounds are compared in AW+1 bits so a window near the top of memory cannot wrap.
  always_comb begin
    addr_ext  = {1'b0, h_req_addr_i};
    lo_ext    = {1'b0, start_addr_i};
    hi_ext    = lo_ext + (AW+1)'(SizeBytes);
    hit       = (addr_ext >= lo_ext) && (addr_ext < hi_ext);
    acc_local = (state_q == IDLE) && h_req_valid_i && hit;
    acc_fwd   = (state_q == IDLE) && h_req_valid_i && !hit && d_req_ready_i;
  end

`ifdef SIM_SRAM_READBACK_EN
  logic [WORDS-1:0][DW-1:0] mem_q, mem_d;
  logic [IW-1:0]            idx;

  always_comb begin
    idx     = IW'((h_req_addr_i - start_addr_i) >> OFFB);
    mem_d   = mem_q;
    rd_word = mem_q[idx];
    if (acc_local && h_req_write_i) begin
      for (int b = 0; b < MW; b++)
        if (h_req_mask_i[b]) mem_d[idx][b*8 +: 8] = h_req_wdata_i[b*8 +: 8];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) mem_q <= '0;
    else       mem_q <= mem_d;
  end
`else
  always_comb rd_word = '0;
`endif

  always_comb begin
    state_d    = state_q;
    rdata_d    = rdata_q;
    source_d   = source_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    unique case (state_q)
      IDLE: begin
        if (acc_local) begin
          state_d  = LOCAL;
          rdata_d  = rd_word;
          source_d = h_req_source_i;
          if (h_req_write_i) begin
            wr_valid_d = 1'b1;
            wr_addr_d  = h_req_addr_i;
            wr_data_d  = h_req_wdata_i;
          end
        end else if (acc_fwd) begin
          state_d = FWD;
        end
      end
      FWD:     if (d_rsp_valid_i && h_rsp_ready_i) state_d = IDLE;
      LOCAL:   if (h_rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      rdata_q    <= '0;
      source_q   <= '0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      rdata_q    <= rdata_d;
      source_q   <= source_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  // Request fields always mirror the host; only valid is gated.
  assign d_req_write_o  = h_req_write_i;
  assign d_req_addr_o   = h_req_addr_i;
  assign d_req_wdata_o  = h_req_wdata_i;
  assign d_req_mask_o   = h_req_mask_i;
  assign d_req_source_o = h_req_source_i;

  always_comb begin
    h_req_ready_o  = 1'b0;
    d_req_valid_o  = 1'b0;
    h_rsp_valid_o  = 1'b0;
    h_rsp_rdata_o  = '0;
    h_rsp_source_o = '0;
    h_rsp_error_o  = 1'b0;
    d_rsp_ready_o  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (hit) begin
          h_req_ready_o = 1'b1;
        end else begin
          d_req_valid_o = h_req_valid_i;
          h_req_ready_o = d_req_ready_i;
        end
      end
      FWD: begin
        h_rsp_valid_o  = d_rsp_valid_i;
        h_rsp_rdata_o  = d_rsp_rdata_i;
        h_rsp_source_o = d_rsp_source_i;
        h_rsp_error_o  = d_rsp_error_i;
        d_rsp_ready_o  = h_rsp_ready_i;
      end
      LOCAL: begin
        h_rsp_valid_o  = 1'b1;
        h_rsp_rdata_o  = rdata_q;
        h_rsp_source_o = source_q;
      end
      default: ;
    endcase
  end

  assign wr_valid_o = wr_valid_q;
  assign wr_addr_o  = wr_addr_q;
  assign wr_data_o  = wr_data_q;
endmodule

// File: tb/tb_sim_sram_window.sv
// Directed bench for sim_sram_window; expected read-back depends on SIM_SRAM_READBACK_EN.
module tb_sim_sram_window;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] start_addr;
  logic        h_req_valid, h_req_ready, h_req_write;
  logic [31:0] h_req_addr, h_req_wdata;
  logic [3:0]  h_req_mask;
  logic [7:0]  h_req_source;
  logic        h_rsp_valid, h_rsp_ready, h_rsp_error;
  logic [31:0] h_rsp_rdata;
  logic [7:0]  h_rsp_source;
  logic        d_req_valid, d_req_ready, d_req_write;
  logic [31:0] d_req_addr, d_req_wdata;
  logic [3:0]  d_req_mask;
  logic [7:0]  d_req_source;
  logic        d_rsp_valid, d_rsp_ready, d_rsp_error;
  logic [31:0] d_rsp_rdata;
  logic [7:0]  d_rsp_source;
  logic        wr_valid;
  logic [31:0] wr_addr, wr_data;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_rb;

  always #5 clk = ~clk;

  sim_sram_window dut (
    .clk_i(clk), .rst_i(rst), .start_addr_i(start_addr),
    .h_req_valid_i(h_req_valid), .h_req_ready_o(h_req_ready), .h_req_write_i(h_req_write),
    .h_req_addr_i(h_req_addr), .h_req_wdata_i(h_req_wdata), .h_req_mask_i(h_req_mask),
    .h_req_source_i(h_req_source),
    .h_rsp_valid_o(h_rsp_valid), .h_rsp_ready_i(h_rsp_ready), .h_rsp_rdata_o(h_rsp_rdata),
    .h_rsp_source_o(h_rsp_source), .h_rsp_error_o(h_rsp_error),
    .d_req_valid_o(d_req_valid), .d_req_ready_i(d_req_ready), .d_req_write_o(d_req_write),
    .d_req_addr_o(d_req_addr), .d_req_wdata_o(d_req_wdata), .d_req_mask_o(d_req_mask),
    .d_req_source_o(d_req_source),
    .d_rsp_valid_i(d_rsp_valid), .d_rsp_ready_o(d_rsp_ready), .d_rsp_rdata_i(d_rsp_rdata),
    .d_rsp_source_i(d_rsp_source), .d_rsp_error_i(d_rsp_error),
    .wr_valid_o(wr_valid), .wr_addr_o(wr_addr), .wr_data_o(wr_data)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request and clocks it in; leaves the request deasserted afterwards.
  task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] m, input logic [7:0] s);
    h_req_valid = 1'b1; h_req_write = wr; h_req_addr = a;
    h_req_wdata = d; h_req_mask = m; h_req_source = s;
    tick();
    h_req_valid = 1'b0;
  endtask

  initial begin
`ifdef SIM_SRAM_READBACK_EN
    exp_rb = 32'hAABB_33DD;
`else
    exp_rb = 32'h0;
`endif
    rst = 1'b1; start_addr = 32'h3000_0000;
    h_req_valid = 0; h_req_write = 0; h_req_addr = 0; h_req_wdata = 0;
    h_req_mask = 0; h_req_source = 0; h_rsp_ready = 0;
    d_req_ready = 0; d_rsp_valid = 0; d_rsp_rdata = 0; d_rsp_source = 0; d_rsp_error = 0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_h_rsp_valid", h_rsp_valid, 0);
    chk("rst_d_req_valid", d_req_valid, 0);
    chk("rst_d_rsp_ready", d_rsp_ready, 0);
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);

    // Idle ready: out-of-window follows device ready, in-window always ready
    h_req_addr = 32'h1000_0000; d_req_ready = 1; #1;
    chk("idle_out_ready1", h_req_ready, 1);
    d_req_ready = 0; #1;
    chk("idle_out_ready0", h_req_ready, 0);
    h_req_addr = 32'h3000_0000; #1;
    chk("idle_in_ready", h_req_ready, 1);

    // Local write
    h_req_valid = 1; h_req_write = 1; h_req_wdata = 32'h0000_900D;
    h_req_mask = 4'hF; h_req_source = 8'd5; #1;
    chk("lw_d_req_valid", d_req_valid, 0);
    tick(); h_req_valid = 0; #1;
    chk("lw_wr_valid", wr_valid, 1);
    chk("lw_wr_addr", wr_addr, 32'h3000_0000);
    chk("lw_wr_data", wr_data, 32'h0000_900D);
    chk("lw_rsp_valid", h_rsp_valid, 1);
    chk("lw_rsp_source", h_rsp_source, 5);
    chk("lw_rsp_error", h_rsp_error, 0);
    chk("lw_d_req_valid2", d_req_valid, 0);
    h_rsp_ready = 1;
    tick();
    chk("lw_wr_pulse_end", wr_valid, 0);
    chk("lw_rsp_done", h_rsp_valid, 0);
    h_rsp_ready = 0;

    // Forwarded read
    h_req_valid = 1; h_req_write = 0; h_req_addr = 32'h1000_0004;
    h_req_source = 8'd3; d_req_ready = 1; #1;
    chk("fw_d_req_valid", d_req_valid, 1);
    chk("fw_d_req_addr", d_req_addr, 32'h1000_0004);
    chk("fw_d_req_source", d_req_source, 3);
    chk("fw_d_req_write", d_req_write, 0);
    chk("fw_h_req_ready", h_req_ready, 1);
    tick();
    h_req_addr = 32'h1000_0008; #1;
    chk("fw_busy_d_req_valid", d_req_valid, 0);
    chk("fw_busy_h_req_ready", h_req_ready, 0);
    h_req_valid = 0; d_req_ready = 0;
    d_rsp_valid = 1; d_rsp_rdata = 32'hCAFE_F00D; d_rsp_error = 1; d_rsp_source = 8'd3;
    h_rsp_ready = 1; #1;
    chk("fw_rsp_valid", h_rsp_valid, 1);
    chk("fw_rsp_rdata", h_rsp_rdata, 32'hCAFE_F00D);
    chk("fw_rsp_error", h_rsp_error, 1);
    chk("fw_rsp_source", h_rsp_source, 3);
    chk("fw_d_rsp_ready", d_rsp_ready, 1);
    tick();
    chk("fw_back_idle_valid", h_rsp_valid, 0);
    chk("fw_stray_d_rsp_ready", d_rsp_ready, 0);
    d_rsp_valid = 0; d_rsp_error = 0;

    // Read-back merge, back-to-back local transactions with h_rsp_ready held high
    issue(1, 32'h3000_0008, 32'hAABB_CCDD, 4'hF, 8'd1);
    chk("rb_w1_valid", h_rsp_valid, 1);
    tick();
    issue(1, 32'h3000_0008, 32'h1122_3344, 4'h2, 8'd2);
    chk("rb_w2_wr_data", wr_data, 32'h1122_3344);
    tick();
    issue(0, 32'h3000_0008, 32'h0, 4'h0, 8'd4);
    chk("rb_rd_valid", h_rsp_valid, 1);
    chk("rb_rd_rdata", h_rsp_rdata, exp_rb);
    chk("rb_rd_source", h_rsp_source, 4);
    chk("rb_rd_no_wr", wr_valid, 0);
    tick();
    h_rsp_ready = 0;

    // Window boundaries (device not ready, so nothing gets clocked in here)
    h_req_valid = 1; h_req_write = 0;
    h_req_addr = 32'h3000_003C; #1;
    chk("bnd_3c_hit", {h_req_ready, d_req_valid}, 2'b10);
    h_req_addr = 32'h3000_0040; #1;
    chk("bnd_40_fwd", {h_req_ready, d_req_valid}, 2'b01);
    h_req_addr = 32'h2FFF_FFFC; #1;
    chk("bnd_below_fwd", {h_req_ready, d_req_valid}, 2'b01);
    start_addr = 32'hFFFF_FFC0; h_req_addr = 32'h0000_0000; #1;
    chk("bnd_nowrap_fwd", {h_req_ready, d_req_valid}, 2'b01);
    h_req_addr = 32'hFFFF_FFFC; #1;
    chk("bnd_top_hit", {h_req_ready, d_req_valid}, 2'b10);
    h_req_valid = 0; start_addr = 32'h3000_0000; #1;

    // Stall in LOCAL, second request blocked, base moved, then reset mid-transaction
    issue(0, 32'h3000_0008, 32'h0, 4'h0, 8'd7);
    h_req_valid = 1; h_req_write = 1; h_req_addr = 32'h3000_0000;
    h_req_wdata = 32'h5555_5555; h_req_mask = 4'hF;
    start_addr = 32'h5000_0000;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_rsp_valid", h_rsp_valid, 1);
      chk("stall_rsp_source", h_rsp_source, 7);
      chk("stall_rsp_rdata", h_rsp_rdata, exp_rb);
      chk("stall_h_req_ready", h_req_ready, 0);
      chk("stall_d_req_valid", d_req_valid, 0);
      chk("stall_wr_valid", wr_valid, 0);
      tick();
    end
    h_req_valid = 0; start_addr = 32'h3000_0000;
    rst = 1; tick(); rst = 0; #1;
    chk("mid_rst_rsp_valid", h_rsp_valid, 0);
    chk("mid_rst_wr_addr", wr_addr, 0);
    chk("mid_rst_wr_data", wr_data, 0);
    chk("mid_rst_idle_ready", h_req_ready, 1);

    // Storage is cleared by reset
    h_rsp_ready = 1;
    issue(0, 32'h3000_0008, 32'h0, 4'h0, 8'd9);
    chk("post_rst_rdata", h_rsp_rdata, 0);
    chk("post_rst_source", h_rsp_source, 9);
    tick();
    chk("post_rst_idle", h_rsp_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sim_sram_window.md
# sim_sram_window

Simulation-only bus interceptor placed between a core's data port and the system crossbar. Requests that fall inside a small, runtime-configurable address window are served by local storage. All other requests pass through unchanged. Every accepted in-window write is also broadcast as a one-cycle event, so a test-status monitor can detect software test termination and pass/fail codes.

## Interface
Parameters:
- AW, 32, address width.
- DW, 32, data width; the byte-mask width is DW/8.
- SRCW, 8, transaction source-ID width.
- SizeBytes, 64, window size in bytes; must be a power of two and at least DW/8.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-high.
- start_addr_i  in  AW  window base address; DW/8-aligned; held stable except while idle.
- h_req_valid_i / h_req_ready_o  in/out  1  host request handshake.
- h_req_write_i  in  1  1 = write, 0 = read.
- h_req_addr_i  in  AW  byte address.
- h_req_wdata_i  in  DW  write data.
- h_req_mask_i  in  DW/8  byte enables.
- h_req_source_i  in  SRCW  source ID.
- h_rsp_valid_o / h_rsp_ready_i  out/in  1  host response handshake.
- h_rsp_rdata_o  out  DW  response read data.
- h_rsp_source_o  out  SRCW  response source ID.
- h_rsp_error_o  out  1  response error flag.
- d_req_* (out; ready in)  same fields as h_req_*  forwarded request to the device side.
- d_rsp_* (in; ready out)  same fields as h_rsp_*  device-side response.
- wr_valid_o  out  1  one-cycle pulse on every accepted in-window write.
- wr_addr_o  out  AW  address of that write.
- wr_data_o  out  DW  write data of that write.

## Operation
- Window hit: start_addr_i <= addr < start_addr_i + SizeBytes. Compute in AW+1 bits so the upper bound cannot wrap.
- Word index is (addr - start_addr_i) >> log2(DW/8). The low address bits are ignored.
- Storage is SizeBytes/(DW/8) words of DW bits.
- At most one transaction is outstanding.
- FSM states: IDLE, FWD, LOCAL.

IDLE:
- In-window request: h_req_ready_o=1; d_req_valid_o=0.
- Out-of-window request: d_req_valid_o=h_req_valid_i, all d_req fields are the host fields unchanged, and h_req_ready_o=d_req_ready_i.
- An accepted forwarded request moves to FWD.
- An accepted in-window request moves to LOCAL and registers source, rdata and error=0.
- In-window write: byte-masked merge into storage; wr_valid_o=1 for that single cycle, with wr_addr_o and wr_data_o registered.

FWD:
- h_req_ready_o=0 and d_req_valid_o=0.
- The h_rsp outputs pass the d_rsp inputs through combinationally, and d_rsp_ready_o=h_rsp_ready_i.
- Return to IDLE on the h_rsp handshake.

LOCAL:
- h_rsp_valid_o=1 with the registered fields; d_rsp_ready_o=0.
- Return to IDLE on h_rsp_ready_i.
- Read data is the storage word as it was at accept time.

Other rules:
- d_rsp_valid_i while not in FWD is ignored; d_rsp_ready_o=0.
- Changing start_addr_i while in LOCAL does not alter the pending response.

## Timing
- Reset values: state IDLE; h_rsp_valid_o, d_req_valid_o, d_rsp_ready_o, wr_valid_o all 0; wr_addr_o and wr_data_o 0; storage cleared to 0.
- Local response latency: h_rsp_valid_o rises 1 cycle after the request accept edge.
- Forwarded path: zero added latency in both directions, and no combinational path from h_req to h_rsp.
- wr_valid_o is registered and high for exactly 1 cycle, the cycle after the accept.
- Reset asserted mid-transaction abandons any pending response. The next cycle is IDLE with all outputs at their reset values.
- Back-to-back: in LOCAL, a new request can be accepted the cycle after the response handshake, giving a throughput of one local transaction per 2 cycles.

## Configuration
- SIM_SRAM_READBACK_EN defined: storage is implemented; in-window reads return the stored word.
- Not defined: no storage flops are instantiated. In-window writes are still acknowledged and still pulse wr_valid_o, but in-window reads return 0.
- Undefined is the default.

## Test plan
- Reset with start_addr_i=0x3000_0000, then idle: all outputs are 0 and h_req_ready_o follows d_req_ready_i only for out-of-window addresses.
- Write 0x0000_900D, mask 0xF, to 0x3000_0000, source 5: wr_valid_o pulses once with addr 0x3000_0000 and data 0x0000_900D. The response arrives 1 cycle later with source 5, error 0; d_req_valid_o stays 0.
- Read from 0x1000_0004: forwarded unchanged. Device response rdata 0xCAFE_F00D, error 1, source 3 appears on the h_rsp outputs the same cycle; the FSM returns to IDLE on the handshake.
- With SIM_SRAM_READBACK_EN: write 0xAABB_CCDD to 0x3000_0008, then write 0x1122_3344 with mask 0x2, then read 0x3000_0008: rdata 0xAABB_33DD. Without the macro the read returns 0.
- Boundary checks:
  - 0x3000_003C hits the window.
  - 0x3000_0040 is forwarded.
  - 0x2FFF_FFFC is forwarded.
  - start_addr_i=0xFFFF_FFC0 with address 0x0000_0000: forwarded (no wrap).
- Hold h_rsp_ready_i=0 in LOCAL for 3 cycles: the response is held stable, a second h_req_valid_i is not accepted, and reset asserted during the stall returns the block to IDLE with h_rsp_valid_o=0.
